// File: rtl/xor_bus_responder.sv
// Memory-mapped XOR decryptor: ciphertext written to DATA is XORed with the key and queued for readback.
// Optional macro XOR_LFSR_KEY_EN turns the key into an 8-bit Fibonacci LFSR keystream.
module xor_bus_responder #(
  parameter int                WORD_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hF0,
  parameter int                DEPTH     = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] bus_in,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [WORD_W-1:0] bus_out,
  output logic              bus_drive
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [WORD_W-1:0] key_reg, key_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;
  logic              err_reg, err_next;
  logic [WORD_W-1:0] bus_out_reg, bus_out_next;
  logic              bus_drive_reg, bus_drive_next;

  logic              hit;
  logic [1:0]        off;
  logic              full;
  logic              empty;
  logic [WORD_W-1:0] status;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;

  assign hit   = (addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
  assign off   = addr[1:0];
  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);

  always_comb begin
    status      = '0;
    status[4:0] = {err_reg, unf_reg, ovf_reg, full, empty};
  end

  always_comb begin
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    key_next       = key_reg;
    ovf_next       = ovf_reg;
    unf_next       = unf_reg;
    err_next       = err_reg;
    bus_out_next   = bus_out_reg;
    bus_drive_next = 1'b0;
    mem_we         = 1'b0;
    mem_wdata      = bus_in ^ key_reg;

    if (hit && wr_en && rd_en) begin
      // Colliding strobes: neither access happens, the bus stays released.
      err_next = 1'b1;
    end else if (hit && wr_en) begin
      case (off)
        2'd0: begin
          if (full) begin
            ovf_next = 1'b1;
          end else begin
            mem_we      = 1'b1;
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
            count_next  = count_reg + CNT_ONE;
`ifdef XOR_LFSR_KEY_EN
            key_next = {key_reg[6:0], key_reg[7] ^ key_reg[5] ^ key_reg[4] ^ key_reg[3]};
`endif
          end
        end
        2'd1: key_next = bus_in;
        2'd3: begin
          if (bus_in[0]) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
          end
          if (bus_in[1]) begin
            ovf_next = 1'b0;
            unf_next = 1'b0;
            err_next = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (hit && rd_en) begin
      bus_drive_next = 1'b1;
      case (off)
        2'd0: begin
          if (empty) begin
            bus_out_next = '0;
            unf_next     = 1'b1;
          end else begin
            bus_out_next = mem[rd_ptr_reg];
            rd_ptr_next  = rd_ptr_reg + PTR_ONE;
            count_next   = count_reg - CNT_ONE;
          end
        end
        2'd1:    bus_out_next = key_reg;
        2'd2:    bus_out_next = status;
        default: bus_out_next = '0;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_ptr_reg] <= mem_wdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      key_reg       <= '0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
      err_reg       <= 1'b0;
      bus_out_reg   <= '0;
      bus_drive_reg <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      key_reg       <= key_next;
      ovf_reg       <= ovf_next;
      unf_reg       <= unf_next;
      err_reg       <= err_next;
      bus_out_reg   <= bus_out_next;
      bus_drive_reg <= bus_drive_next;
    end
  end

  assign bus_out   = bus_out_reg;
  assign bus_drive = bus_drive_reg;

endmodule

// File: tb/tb_xor_bus_responder.sv
// Scoreboard bench for xor_bus_responder: reads queue their expected data, a monitor checks each driven cycle.
module tb_xor_bus_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [7:0] bus_in = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] bus_out;
  logic       bus_drive;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  localparam logic [7:0] A_DATA = 8'hF0;
  localparam logic [7:0] A_KEY  = 8'hF1;
  localparam logic [7:0] A_STAT = 8'hF2;
  localparam logic [7:0] A_CTRL = 8'hF3;

`ifdef XOR_LFSR_KEY_EN
  localparam logic [7:0] EXP_SECOND = 8'hB4;
`else
  localparam logic [7:0] EXP_SECOND = 8'h5A;
`endif

  xor_bus_responder dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .bus_in    (bus_in),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .bus_out   (bus_out),
    .bus_drive (bus_drive)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end else begin
      $display("ok   %s value=%h", name, actual);
    end
  endtask

  // Monitor: every driven cycle must match the oldest outstanding read.
  always @(negedge clock) begin
    if (!reset && bus_drive !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_drive bus_drive=%b bus_out=%h expected=no_drive", bus_drive, bus_out);
      end else begin
        check("read_data", bus_out, exp_q.pop_front());
      end
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; bus_in = d; wr_en = 1'b1;
    @(posedge clock); #1;
    wr_en = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] e);
    addr = a; rd_en = 1'b1;
    exp_q.push_back(e);
    @(posedge clock); #1;
    rd_en = 1'b0;
    $display("read  addr=%h expect=%h", a, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_drive", {7'b0, bus_drive}, 8'h00);
    check("reset_out", bus_out, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    // Reset pulse while a read is being driven
    bus_write(A_KEY, 8'h77);
    bus_read(A_KEY, 8'h77);
    @(negedge clock); #1;
    reset = 1'b1; #1;
    check("midreset_drive", {7'b0, bus_drive}, 8'h00);
    check("midreset_out", bus_out, 8'h00);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    bus_read(A_STAT, 8'h01);
    bus_read(A_KEY, 8'h00);
    idle(2);

    // Basic decrypt, single-cycle drive
    bus_write(A_KEY, 8'h5A);
    bus_write(A_DATA, 8'h3B);
    bus_read(A_DATA, 8'h61);
    idle(3);

    // Keystream vs static key
    bus_write(A_KEY, 8'h5A);
    bus_write(A_DATA, 8'h3B);
    bus_write(A_DATA, 8'h00);
    bus_read(A_DATA, 8'h61);
    bus_read(A_DATA, EXP_SECOND);
    idle(2);

    // Overflow and underflow boundaries
    bus_write(A_KEY, 8'h00);
    for (int i = 1; i <= 5; i++) bus_write(A_DATA, 8'(i));
    bus_read(A_STAT, 8'h06);
    for (int i = 1; i <= 4; i++) bus_read(A_DATA, 8'(i));
    bus_read(A_DATA, 8'h00);
    bus_read(A_STAT, 8'h0D);
    bus_write(A_CTRL, 8'h02);
    bus_read(A_STAT, 8'h01);
    idle(2);

    // Colliding strobes: no access, err set, no drive
    bus_write(A_DATA, 8'h10);
    addr = A_DATA; bus_in = 8'h99; wr_en = 1'b1; rd_en = 1'b1;
    @(posedge clock); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    $display("collide addr=%h data=%h expect=no_drive", A_DATA, 8'h99);
    idle(2);
    bus_read(A_STAT, 8'h10);
    bus_read(A_DATA, 8'h10);
    bus_read(A_STAT, 8'h11);
    bus_write(A_CTRL, 8'h02);
    bus_read(A_STAT, 8'h01);
    idle(2);

    // Decode miss is ignored
    bus_write(8'hE0, 8'h55);
    bus_write(8'hE1, 8'hAA);
    bus_read(8'hE0, 8'h00);
    exp_q.pop_back();
    idle(2);
    bus_read(A_STAT, 8'h01);
    bus_read(A_KEY, 8'h00);

    // Flush with entries queued, then combined flush+clear
    bus_write(A_DATA, 8'h21);
    bus_write(A_DATA, 8'h22);
    bus_write(A_DATA, 8'h23);
    bus_read(A_STAT, 8'h00);
    bus_write(A_CTRL, 8'h01);
    bus_read(A_STAT, 8'h01);
    bus_read(A_DATA, 8'h00);
    bus_read(A_STAT, 8'h09);
    bus_write(A_DATA, 8'h44);
    bus_write(A_CTRL, 8'h03);
    bus_read(A_STAT, 8'h01);

    // Reset discards queued data
    bus_write(A_DATA, 8'h31);
    bus_write(A_DATA, 8'h32);
    @(negedge clock); #1;
    reset = 1'b1; #2 reset = 1'b0;
    @(posedge clock); #1;
    bus_read(A_STAT, 8'h01);
    idle(3);

    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
